// File: rtl/map_arb_pkg.sv
// Shared types for the mapper external-memory arbiter: FSM states,
// requester identifiers and the loader starvation counter width.
package map_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } arb_state_t;

    typedef enum logic [1:0] {
        REQ_PRG,
        REQ_CHR,
        REQ_LDR
    } req_id_t;

    localparam int LDR_WAIT_W = 8;

endpackage

// File: rtl/map_mem_arbiter.sv
// Shares one external-memory port between the mapper PRG path, the mapper
// CHR path and the cartridge loader; one transaction in flight at a time.
module map_mem_arbiter
    import map_arb_pkg::*;
#(
    parameter int ADDR_BITS    = 24,
    parameter int DATA_BITS    = 8,
    parameter int LDR_MAX_WAIT = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,

    input  logic                 prg_req,
    input  logic                 prg_we,
    input  logic [ADDR_BITS-1:0] prg_addr,
    input  logic [DATA_BITS-1:0] prg_wdata,
    output logic                 prg_ack,
    output logic [DATA_BITS-1:0] prg_rdata,

    input  logic                 chr_req,
    input  logic                 chr_we,
    input  logic [ADDR_BITS-1:0] chr_addr,
    input  logic [DATA_BITS-1:0] chr_wdata,
    output logic                 chr_ack,
    output logic [DATA_BITS-1:0] chr_rdata,

    input  logic                 ldr_req,
    input  logic                 ldr_we,
    input  logic [ADDR_BITS:0]   ldr_addr,
    input  logic [DATA_BITS-1:0] ldr_wdata,
    output logic                 ldr_ack,
    output logic [DATA_BITS-1:0] ldr_rdata,

    output logic                 mem_req,
    output logic                 mem_we,
    output logic [ADDR_BITS:0]   mem_addr,
    output logic [DATA_BITS-1:0] mem_wdata,
    input  logic                 mem_ack,
    input  logic [DATA_BITS-1:0] mem_rdata
);

    arb_state_t              state_q, state_d;
    req_id_t                 winner_q, winner_d;
    logic                    grant_vld;
    logic                    last_chr_q;
    logic [LDR_WAIT_W-1:0]   ldr_wait_q;
    logic                    ldr_starved;
    logic                    ldr_served;
    logic                    sel_we;
    logic [ADDR_BITS:0]      sel_addr;
    logic [DATA_BITS-1:0]    sel_wdata;

    assign ldr_starved = ldr_req && (ldr_wait_q >= LDR_WAIT_W'(LDR_MAX_WAIT));

    // Winner selection; only meaningful while IDLE.
    always_comb begin
        winner_d  = REQ_PRG;
        grant_vld = (state_q == IDLE) && (prg_req || chr_req || ldr_req);
        if (ldr_starved) begin
            winner_d = REQ_LDR;
        end else if (prg_req && chr_req) begin
            winner_d = last_chr_q ? REQ_PRG : REQ_CHR;
        end else if (prg_req) begin
            winner_d = REQ_PRG;
        end else if (chr_req) begin
            winner_d = REQ_CHR;
        end else if (ldr_req) begin
            winner_d = REQ_LDR;
        end

        sel_we    = prg_we;
        sel_addr  = {1'b0, prg_addr};
        sel_wdata = prg_wdata;
        case (winner_d)
            REQ_CHR: begin
                sel_we    = chr_we;
                sel_addr  = {1'b1, chr_addr};
                sel_wdata = chr_wdata;
            end
            REQ_LDR: begin
                sel_we    = ldr_we;
                sel_addr  = ldr_addr;
                sel_wdata = ldr_wdata;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_vld) state_d = BUSY;
            BUSY:    if (mem_ack)   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The loader stops accumulating wait time from its grant until its ack.
    assign ldr_served = (grant_vld && (winner_d == REQ_LDR)) ||
                        ((state_q != IDLE) && (winner_q == REQ_LDR));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            winner_q   <= REQ_PRG;
            last_chr_q <= 1'b1;
            ldr_wait_q <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            prg_ack    <= 1'b0;
            chr_ack    <= 1'b0;
            ldr_ack    <= 1'b0;
            prg_rdata  <= '0;
            chr_rdata  <= '0;
            ldr_rdata  <= '0;
        end else begin
            prg_ack <= 1'b0;
            chr_ack <= 1'b0;
            ldr_ack <= 1'b0;

            if (grant_vld) begin
                winner_q  <= winner_d;
                mem_req   <= 1'b1;
                mem_we    <= sel_we;
                mem_addr  <= sel_addr;
                mem_wdata <= sel_wdata;
                if (winner_d != REQ_LDR) begin
                    last_chr_q <= (winner_d == REQ_CHR);
                end
            end

            if ((state_q == BUSY) && mem_ack) begin
                mem_req <= 1'b0;
                case (winner_q)
                    REQ_PRG: begin
                        prg_ack <= 1'b1;
                        if (!mem_we) prg_rdata <= mem_rdata;
                    end
                    REQ_CHR: begin
                        chr_ack <= 1'b1;
                        if (!mem_we) chr_rdata <= mem_rdata;
                    end
                    default: begin
                        ldr_ack <= 1'b1;
                        if (!mem_we) ldr_rdata <= mem_rdata;
                    end
                endcase
            end

            if (!ldr_req || ldr_served) begin
                ldr_wait_q <= '0;
            end else if (ldr_wait_q != '1) begin
                ldr_wait_q <= ldr_wait_q + LDR_WAIT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_map_mem_arbiter.sv
// Bench for map_mem_arbiter: table-driven single transactions plus
// contention, loader starvation and reset-during-transaction sequences.
module tb_map_mem_arbiter;

    localparam int ID_PRG = 0;
    localparam int ID_CHR = 1;
    localparam int ID_LDR = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        prg_req = 0, prg_we = 0;
    logic [23:0] prg_addr = '0;
    logic [7:0]  prg_wdata = '0;
    logic        prg_ack;
    logic [7:0]  prg_rdata;
    logic        chr_req = 0, chr_we = 0;
    logic [23:0] chr_addr = '0;
    logic [7:0]  chr_wdata = '0;
    logic        chr_ack;
    logic [7:0]  chr_rdata;
    logic        ldr_req = 0, ldr_we = 0;
    logic [24:0] ldr_addr = '0;
    logic [7:0]  ldr_wdata = '0;
    logic        ldr_ack;
    logic [7:0]  ldr_rdata;
    logic        mem_req, mem_we;
    logic [24:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_ack = 1'b0;
    logic [7:0]  mem_rdata = '0;

    int checks = 0;
    int errors = 0;

    map_mem_arbiter #(.ADDR_BITS(24), .DATA_BITS(8), .LDR_MAX_WAIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .prg_req(prg_req), .prg_we(prg_we), .prg_addr(prg_addr), .prg_wdata(prg_wdata),
        .prg_ack(prg_ack), .prg_rdata(prg_rdata),
        .chr_req(chr_req), .chr_we(chr_we), .chr_addr(chr_addr), .chr_wdata(chr_wdata),
        .chr_ack(chr_ack), .chr_rdata(chr_rdata),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
        .ldr_ack(ldr_ack), .ldr_rdata(ldr_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic        we;
        logic [24:0] maddr;
        logic [7:0]  wdata;
    } exp_t;

    typedef struct {
        int          id;
        logic        we;
        logic [24:0] addr;
        logic [7:0]  wdata;
        int          lat;
        logic [24:0] exp_maddr;
    } vec_t;

    exp_t sb[$];

    // Memory model: read data is a fixed function of the address.
    int  resp_lat = 1;
    bit  resp_en = 1'b1;
    int  manual_pulse = 0;
    int  resp_wait = 0;

    initial begin
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (manual_pulse > 0) begin
                mem_ack = 1'b1;
                mem_rdata = 8'hEE;
                manual_pulse = manual_pulse - 1;
            end else if (resp_en && rst_n && mem_req) begin
                if (resp_wait >= resp_lat - 1) begin
                    mem_ack = 1'b1;
                    mem_rdata = mem_addr[7:0] ^ 8'h91;
                    resp_wait = 0;
                end else begin
                    resp_wait = resp_wait + 1;
                end
            end else begin
                resp_wait = 0;
            end
        end
    end

    // Monitor / scoreboard.
    logic        prev_req = 1'b0;
    logic [24:0] cap_addr = '0;
    logic        cap_we = 1'b0;
    logic [7:0]  cap_wd = '0;
    logic [7:0]  sh_prg = '0, sh_chr = '0, sh_ldr = '0;

    initial begin
        exp_t e;
        int   got_id;
        int   n_acks;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                prev_req = 1'b0;
                sh_prg = '0; sh_chr = '0; sh_ldr = '0;
            end else begin
                if (mem_req && !prev_req) begin
                    cap_addr = mem_addr; cap_we = mem_we; cap_wd = mem_wdata;
                end else if (mem_req && prev_req) begin
                    checks++;
                    if (mem_addr !== cap_addr || mem_we !== cap_we || mem_wdata !== cap_wd) begin
                        errors++;
                        $display("FAIL mem_stable: addr=%h we=%b wd=%h, required addr=%h we=%b wd=%h",
                                 mem_addr, mem_we, mem_wdata, cap_addr, cap_we, cap_wd);
                    end
                end
                n_acks = int'(prg_ack) + int'(chr_ack) + int'(ldr_ack);
                if (n_acks != 0) begin
                    got_id = prg_ack ? ID_PRG : (chr_ack ? ID_CHR : ID_LDR);
                    checks++;
                    if (n_acks != 1 || !mem_ack || !prev_req) begin
                        errors++;
                        $display("FAIL ack_timing: acks=%0d mem_ack=%b prev_mem_req=%b, required 1 ack right after mem_ack",
                                 n_acks, mem_ack, prev_req);
                    end
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_ack: id=%0d, required no ack", got_id);
                    end else begin
                        e = sb.pop_front();
                        if (got_id != e.id) begin
                            errors++;
                            $display("FAIL ack_id: got %0d, required %0d", got_id, e.id);
                        end
                        checks++;
                        if (cap_addr !== e.maddr || cap_we !== e.we || (e.we && cap_wd !== e.wdata)) begin
                            errors++;
                            $display("FAIL mem_fields: addr=%h we=%b wd=%h, required addr=%h we=%b wd=%h",
                                     cap_addr, cap_we, cap_wd, e.maddr, e.we, e.wdata);
                        end
                        if (!e.we) begin
                            case (e.id)
                                ID_PRG:  sh_prg = e.maddr[7:0] ^ 8'h91;
                                ID_CHR:  sh_chr = e.maddr[7:0] ^ 8'h91;
                                default: sh_ldr = e.maddr[7:0] ^ 8'h91;
                            endcase
                        end
                        checks++;
                        if (prg_rdata !== sh_prg || chr_rdata !== sh_chr || ldr_rdata !== sh_ldr) begin
                            errors++;
                            $display("FAIL rdata: prg=%h chr=%h ldr=%h, required prg=%h chr=%h ldr=%h",
                                     prg_rdata, chr_rdata, ldr_rdata, sh_prg, sh_chr, sh_ldr);
                        end
                    end
                end
                prev_req = mem_req;
            end
        end
    end

    function automatic logic all_zero();
        return !prg_ack && !chr_ack && !ldr_ack && !mem_req && !mem_we &&
               mem_addr == '0 && mem_wdata == '0 &&
               prg_rdata == '0 && chr_rdata == '0 && ldr_rdata == '0;
    endfunction

    function automatic logic ack_of(input int id);
        case (id)
            ID_PRG:  return prg_ack;
            ID_CHR:  return chr_ack;
            default: return ldr_ack;
        endcase
    endfunction

    function automatic void push_exp(input int id, input logic we, input logic [24:0] maddr,
                                     input logic [7:0] wd);
        exp_t e;
        e.id = id; e.we = we; e.maddr = maddr; e.wdata = wd;
        sb.push_back(e);
    endfunction

    task automatic set_req(input int id, input logic r, input logic we,
                           input logic [24:0] a, input logic [7:0] wd);
        case (id)
            ID_PRG:  begin prg_req = r; prg_we = we; prg_addr = a[23:0]; prg_wdata = wd; end
            ID_CHR:  begin chr_req = r; chr_we = we; chr_addr = a[23:0]; chr_wdata = wd; end
            default: begin ldr_req = r; ldr_we = we; ldr_addr = a;       ldr_wdata = wd; end
        endcase
    endtask

    task automatic wait_acks(input int id, input int n);
        int got = 0;
        int cyc = 0;
        while (got < n && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
            if (ack_of(id)) got++;
        end
        checks++;
        if (got < n) begin
            errors++;
            $display("FAIL ack_timeout: id=%0d got %0d acks, required %0d", id, got, n);
        end
    endtask

    task automatic run_req(input int id, input logic we, input logic [24:0] a,
                           input logic [7:0] wd, input int n);
        set_req(id, 1'b1, we, a, wd);
        wait_acks(id, n);
        @(negedge clk);
        set_req(id, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    vec_t tbl[7];

    initial begin
        int waited;
        tbl[0] = '{ID_PRG, 1'b0, 25'h0001234, 8'h00, 3, 25'h0001234};
        tbl[1] = '{ID_CHR, 1'b0, 25'h0000055, 8'h00, 1, 25'h1000055};
        tbl[2] = '{ID_LDR, 1'b1, 25'h1000010, 8'h3C, 2, 25'h1000010};
        tbl[3] = '{ID_PRG, 1'b1, 25'h0FFFFFF, 8'h81, 1, 25'h0FFFFFF};
        tbl[4] = '{ID_LDR, 1'b0, 25'h0ABCDEF, 8'h00, 4, 25'h0ABCDEF};
        tbl[5] = '{ID_CHR, 1'b1, 25'h0FFFFFF, 8'h7E, 2, 25'h1FFFFFF};
        tbl[6] = '{ID_CHR, 1'b0, 25'h0000000, 8'h00, 1, 25'h1000000};

        // Reset: outputs idle during and for 10 cycles after reset.
        repeat (3) @(negedge clk);
        checks++;
        if (!all_zero()) begin
            errors++;
            $display("FAIL reset_hold: outputs not all zero, required all zero");
        end
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (!all_zero()) begin
                errors++;
                $display("FAIL reset_idle: cycle %0d mem_req=%b acks=%b%b%b, required all zero",
                         i, mem_req, prg_ack, chr_ack, ldr_ack);
            end
        end

        // Single transactions from the table.
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            resp_lat = tbl[i].lat;
            push_exp(tbl[i].id, tbl[i].we, tbl[i].exp_maddr, tbl[i].wdata);
            set_req(tbl[i].id, 1'b1, tbl[i].we, tbl[i].addr, tbl[i].wdata);
            @(posedge clk);
            #1;
            checks++;
            if (mem_req !== 1'b1) begin
                errors++;
                $display("FAIL req_latency: vec %0d mem_req=%b, required 1", i, mem_req);
            end
            wait_acks(tbl[i].id, 1);
            @(negedge clk);
            set_req(tbl[i].id, 1'b0, 1'b0, '0, '0);
        end

        // PRG/CHR contention alternates starting with PRG.
        do_reset();
        resp_lat = 2;
        for (int i = 0; i < 3; i++) begin
            push_exp(ID_PRG, 1'b0, 25'h0000111, 8'h00);
            push_exp(ID_CHR, 1'b0, 25'h1000222, 8'h00);
        end
        fork
            run_req(ID_PRG, 1'b0, 25'h0000111, 8'h00, 3);
            run_req(ID_CHR, 1'b0, 25'h0000222, 8'h00, 3);
        join
        repeat (3) @(negedge clk);

        // Loader starvation: PRG, CHR, then the starved loader, then PRG.
        do_reset();
        resp_lat = 1;
        push_exp(ID_PRG, 1'b0, 25'h000A0A0, 8'h00);
        push_exp(ID_CHR, 1'b0, 25'h100B0B0, 8'h00);
        push_exp(ID_LDR, 1'b0, 25'h1C0C0C0, 8'h00);
        push_exp(ID_PRG, 1'b0, 25'h000A0A0, 8'h00);
        fork
            run_req(ID_PRG, 1'b0, 25'h000A0A0, 8'h00, 2);
            run_req(ID_CHR, 1'b0, 25'h000B0B0, 8'h00, 1);
            run_req(ID_LDR, 1'b0, 25'h1C0C0C0, 8'h00, 1);
        join
        repeat (3) @(negedge clk);

        // Reset while BUSY, then a stale mem_ack.
        resp_en = 1'b0;
        @(negedge clk);
        set_req(ID_PRG, 1'b1, 1'b0, 25'h0000777, 8'h00);
        waited = 0;
        while (!mem_req && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (!mem_req) begin
            errors++;
            $display("FAIL busy_reach: mem_req=%b, required 1", mem_req);
        end
        rst_n = 1'b0;
        set_req(ID_PRG, 1'b0, 1'b0, '0, '0);
        #1;
        checks++;
        if (!all_zero()) begin
            errors++;
            $display("FAIL reset_busy: mem_req=%b mem_addr=%h, required all zero", mem_req, mem_addr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(posedge clk);
        manual_pulse = 1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (mem_req || prg_ack || chr_ack || ldr_ack) begin
                errors++;
                $display("FAIL stale_ack: cycle %0d mem_req=%b acks=%b%b%b, required all 0",
                         i, mem_req, prg_ack, chr_ack, ldr_ack);
            end
        end
        resp_en = 1'b1;
        resp_lat = 1;
        @(negedge clk);
        push_exp(ID_CHR, 1'b0, 25'h1000099, 8'h00);
        run_req(ID_CHR, 1'b0, 25'h0000099, 8'h00, 1);
        repeat (3) @(negedge clk);

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d pending, required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running, required completion");
        $fatal(1);
    end

endmodule
